axi_rd_burst_arbiter: RTL

- Shares one AXI4 read-address/read-data path between two burst requesters.
- Requester 0 is the bitmap display engine (frame-buffer refill); requester 1 is a secondary reader (e.g. HOG feature fetch).
- Each requester uses the engine-style req/ack + ARLEN + address handshake. The downstream side drives the AXI4 master front end.
- One burst is outstanding at a time. Read beats (data_valid) are steered to the current burst owner.

---
 rtl/axi_rd_burst_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/axi_rd_burst_arbiter.sv
// ----------------------------------------------------------------------------
// axi_rd_burst_arbiter
//   Shares one AXI4 read-address/read-data path between two burst requesters.
//   Requester 0 is the bitmap display engine, requester 1 a secondary reader.
//   One burst is outstanding at a time; read beats are steered to the owner.
//
//   Arbitration: fixed priority (requester 0 wins) by default. When the macro
//   AXI_RD_ARB_RR_EN is defined, contention is resolved round-robin using a
//   last_grant register.
//
// Handshakes:
//   sN_req is held high by the requester until sN_ack. sN_ack is a zero-latency
//   copy of m_ack for the owner while in ADDR. A beat (m_data_valid) is accepted
//   in DATA, or in ADDR in the same cycle as m_ack; any other beat is dropped
//   and sets the sticky stray_beat flag.
//
// Ports:
//   clk_axi, reset_axi_n        clock, synchronous active-low reset
//   s0_* / s1_*                 requester req/ack, arlen, address, data_valid
//   m_req/m_ack/m_arlen/m_address  master address handshake (latched values)
//   m_data_in/m_data_valid      read data from the master
//   data_out                    m_data_in broadcast combinationally
//   owner, busy, stray_beat     status outputs
//   state_dbg                   current FSM state (0 IDLE, 1 ADDR, 2 DATA)
// ----------------------------------------------------------------------------
module axi_rd_burst_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 64,
   parameter int BEAT_CNT_W = 9
) (
   input  logic              clk_axi,
   input  logic              reset_axi_n,
   input  logic              s0_req,
   output logic              s0_ack,
   input  logic [7:0]        s0_arlen,
   input  logic [ADDR_W-1:0] s0_address,
   output logic              s0_data_valid,
   input  logic              s1_req,
   output logic              s1_ack,
   input  logic [7:0]        s1_arlen,
   input  logic [ADDR_W-1:0] s1_address,
   output logic              s1_data_valid,
   output logic              m_req,
   input  logic              m_ack,
   output logic [7:0]        m_arlen,
   output logic [ADDR_W-1:0] m_address,
   input  logic [DATA_W-1:0] m_data_in,
   input  logic              m_data_valid,
   output logic [DATA_W-1:0] data_out,
   output logic              owner,
   output logic              busy,
   output logic              stray_beat,
   output logic [1:0]        state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   localparam logic [BEAT_CNT_W-1:0] CNT_ONE = {{(BEAT_CNT_W-1){1'b0}}, 1'b1};

   state_t                state_q, state_d;
   logic                  m_req_q, m_req_d;
   logic [7:0]            m_arlen_q, m_arlen_d;
   logic [ADDR_W-1:0]     m_address_q, m_address_d;
   logic                  owner_q, owner_d;
   logic                  busy_q, busy_d;
   logic                  stray_q, stray_d;
   logic [BEAT_CNT_W-1:0] cnt_q, cnt_d;
   logic                  winner;
   logic [7:0]            win_arlen;
   logic                  beat_accept;

`ifdef AXI_RD_ARB_RR_EN
   logic last_grant_q, last_grant_d;

   // Under contention the requester that did not win last time goes first.
   always_comb begin
      winner = ~s0_req;
      if (s0_req && s1_req) begin
         winner = ~last_grant_q;
      end
   end
`else
   always_comb begin
      winner = ~s0_req;
   end
`endif

   assign win_arlen = winner ? s1_arlen : s0_arlen;

   // A beat coincident with m_ack is the first beat of the burst.
   assign beat_accept = m_data_valid &&
                        ((state_q == DATA) || ((state_q == ADDR) && m_ack));

   always_comb begin
      state_d     = state_q;
      m_req_d     = m_req_q;
      m_arlen_d   = m_arlen_q;
      m_address_d = m_address_q;
      owner_d     = owner_q;
      stray_d     = stray_q;
      cnt_d       = cnt_q;
`ifdef AXI_RD_ARB_RR_EN
      last_grant_d = last_grant_q;
`endif
      case (state_q)
         IDLE: begin
            if (m_data_valid) begin
               stray_d = 1'b1;
            end
            if (s0_req || s1_req) begin
               owner_d     = winner;
               m_address_d = winner ? s1_address : s0_address;
               m_arlen_d   = win_arlen;
               m_req_d     = 1'b1;
               // Widened before the +1 so ARLEN=255 yields 256, not 0.
               cnt_d       = {{(BEAT_CNT_W-8){1'b0}}, win_arlen} + CNT_ONE;
               state_d     = ADDR;
`ifdef AXI_RD_ARB_RR_EN
               last_grant_d = winner;
`endif
            end
         end
         ADDR: begin
            if (m_ack) begin
               m_req_d = 1'b0;
               state_d = DATA;
               if (m_data_valid) begin
                  cnt_d = cnt_q - CNT_ONE;
                  if (cnt_q == CNT_ONE) begin
                     state_d = IDLE;
                  end
               end
            end else if (m_data_valid) begin
               stray_d = 1'b1;
            end
         end
         DATA: begin
            if (m_data_valid) begin
               cnt_d = cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            m_req_d = 1'b0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_axi) begin
      if (!reset_axi_n) begin
         state_q     <= IDLE;
         m_req_q     <= 1'b0;
         m_arlen_q   <= 8'd0;
         m_address_q <= '0;
         owner_q     <= 1'b0;
         busy_q      <= 1'b0;
         stray_q     <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         m_req_q     <= m_req_d;
         m_arlen_q   <= m_arlen_d;
         m_address_q <= m_address_d;
         owner_q     <= owner_d;
         busy_q      <= busy_d;
         stray_q     <= stray_d;
         cnt_q       <= cnt_d;
      end
   end

`ifdef AXI_RD_ARB_RR_EN
   always_ff @(posedge clk_axi) begin
      if (!reset_axi_n) begin
         last_grant_q <= 1'b0;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end
`endif

   assign s0_ack        = m_ack && (state_q == ADDR) && !owner_q;
   assign s1_ack        = m_ack && (state_q == ADDR) &&  owner_q;
   assign s0_data_valid = beat_accept && !owner_q;
   assign s1_data_valid = beat_accept &&  owner_q;
   assign m_req         = m_req_q;
   assign m_arlen       = m_arlen_q;
   assign m_address     = m_address_q;
   assign data_out      = m_data_in;
   assign owner         = owner_q;
   assign busy          = busy_q;
   assign stray_beat    = stray_q;
   assign state_dbg     = state_q;

endmodule
